// File: rtl/key_debounce.sv
// key_debounce: debounces one active-low mechanical push-button and produces
// a clean pressed level plus one-cycle press / release / long-press events.
// Timebase: free-running 1 us prescaler feeding a 1 ms tick counter.
// Optional feature: define KEY_REPEAT_EN to enable the auto-repeat pulse
// (key_repeat); without it key_repeat is tied to 0.
module key_debounce #(
   parameter int CLK_PER_US  = 24,
   parameter int US_PER_MS   = 1000,
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000,
   parameter int REPEAT_MS   = 200
) (
   input  logic clk,
   input  logic reset,
   input  logic key_in,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic key_repeat
);

   localparam int US_W   = $clog2(CLK_PER_US) + 1;
   localparam int MS_W   = $clog2(US_PER_MS) + 1;
   localparam int DEB_W  = $clog2(DEBOUNCE_MS) + 1;
   localparam int HOLD_W = $clog2(LONG_MS) + 1;

   // Reject parameter sets the timing logic cannot represent.
   if (!((CLK_PER_US >= 2) && (US_PER_MS >= 2) && (DEBOUNCE_MS >= 1) &&
         (LONG_MS > DEBOUNCE_MS) && (REPEAT_MS >= 1))) begin : g_param_check
      $error("key_debounce: illegal parameter set");
   end

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CHK = 2'd1,
      PRESSED   = 2'd2,
      REL_CHK   = 2'd3
   } state_t;

   logic              sync1_r;
   logic              sync2_r;
   logic              key_s;
   logic [US_W-1:0]   us_cnt_r;
   logic              us_tick_s;
   logic [MS_W-1:0]   ms_cnt_r;
   logic              ms_tick_s;
   state_t            state_r;
   state_t            next_state_s;
   logic [DEB_W-1:0]  deb_cnt_r;
   logic              deb_done_s;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic              held_s;
   logic              level_s;
   logic              press_s;
   logic              release_s;
   logic              long_s;
   logic              repeat_s;
   logic              key_level_r;
   logic              key_press_r;
   logic              key_release_r;
   logic              key_long_r;
   logic              key_repeat_r;

   // Two-flop synchroniser; idles at 1 (released) so reset never looks like a press.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= key_in;
         sync2_r <= sync1_r;
      end
   end

   assign key_s = ~sync2_r;

   assign us_tick_s = (us_cnt_r == US_W'(CLK_PER_US - 1));
   assign ms_tick_s = us_tick_s && (ms_cnt_r == MS_W'(US_PER_MS - 1));

   // Free-running 1 us prescaler and 1 ms counter; never restarted by the FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         us_cnt_r <= US_W'(0);
         ms_cnt_r <= MS_W'(0);
      end else begin
         if (us_tick_s) begin
            us_cnt_r <= US_W'(0);
            if (ms_cnt_r == MS_W'(US_PER_MS - 1)) begin
               ms_cnt_r <= MS_W'(0);
            end else begin
               ms_cnt_r <= ms_cnt_r + MS_W'(1);
            end
         end else begin
            us_cnt_r <= us_cnt_r + US_W'(1);
         end
      end
   end

   assign deb_done_s = ms_tick_s && (deb_cnt_r == DEB_W'(DEBOUNCE_MS - 1));
   assign held_s     = (state_r == PRESSED) || (state_r == REL_CHK);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic: a new level must survive DEBOUNCE_MS ticks to be accepted.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (key_s) begin
               next_state_s = PRESS_CHK;
            end else begin
               next_state_s = IDLE;
            end
         end
         PRESS_CHK: begin
            if (!key_s) begin
               next_state_s = IDLE;
            end else if (deb_done_s) begin
               next_state_s = PRESSED;
            end else begin
               next_state_s = PRESS_CHK;
            end
         end
         PRESSED: begin
            if (!key_s) begin
               next_state_s = REL_CHK;
            end else begin
               next_state_s = PRESSED;
            end
         end
         REL_CHK: begin
            if (key_s) begin
               next_state_s = PRESSED;
            end else if (deb_done_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = REL_CHK;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // FSM output logic: next values of the registered event and level outputs.
   always_comb begin
      press_s   = (state_r == PRESS_CHK) && (next_state_s == PRESSED);
      release_s = (state_r == REL_CHK) && (next_state_s == IDLE);
      level_s   = (next_state_s == PRESSED) || (next_state_s == REL_CHK);
      long_s    = held_s && ms_tick_s && (hold_cnt_r == HOLD_W'(LONG_MS - 1));
   end

   // Debounce counter: restarts on every state change, counts ms ticks while checking.
   always_ff @(posedge clk) begin
      if (reset) begin
         deb_cnt_r <= DEB_W'(0);
      end else if (next_state_s != state_r) begin
         deb_cnt_r <= DEB_W'(0);
      end else if (((state_r == PRESS_CHK) || (state_r == REL_CHK)) && ms_tick_s) begin
         deb_cnt_r <= deb_cnt_r + DEB_W'(1);
      end else begin
         deb_cnt_r <= deb_cnt_r;
      end
   end

   // Hold counter: starts at press acceptance, survives release glitches, saturates at LONG_MS.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt_r <= HOLD_W'(0);
      end else if (press_s) begin
         hold_cnt_r <= HOLD_W'(0);
      end else if (held_s && ms_tick_s && (hold_cnt_r < HOLD_W'(LONG_MS))) begin
         hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      end else begin
         hold_cnt_r <= hold_cnt_r;
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_MS) + 1;

   logic [REP_W-1:0] rep_cnt_r;
   logic             rep_active_s;

   // Repeat runs only once the hold counter has saturated, i.e. after key_long fired.
   assign rep_active_s = held_s && (hold_cnt_r == HOLD_W'(LONG_MS));
   assign repeat_s     = rep_active_s && ms_tick_s && (rep_cnt_r == REP_W'(REPEAT_MS - 1));

   // Repeat period counter; cleared on accepted release.
   always_ff @(posedge clk) begin
      if (reset) begin
         rep_cnt_r <= REP_W'(0);
      end else if (release_s) begin
         rep_cnt_r <= REP_W'(0);
      end else if (rep_active_s && ms_tick_s) begin
         if (rep_cnt_r == REP_W'(REPEAT_MS - 1)) begin
            rep_cnt_r <= REP_W'(0);
         end else begin
            rep_cnt_r <= rep_cnt_r + REP_W'(1);
         end
      end else begin
         rep_cnt_r <= rep_cnt_r;
      end
   end
`else
   assign repeat_s = 1'b0;
`endif

   // Output registers; reset drops everything without emitting a release.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_level_r   <= 1'b0;
         key_press_r   <= 1'b0;
         key_release_r <= 1'b0;
         key_long_r    <= 1'b0;
         key_repeat_r  <= 1'b0;
      end else begin
         key_level_r   <= level_s;
         key_press_r   <= press_s;
         key_release_r <= release_s;
         key_long_r    <= long_s;
         key_repeat_r  <= repeat_s;
      end
   end

   assign key_level   = key_level_r;
   assign key_press   = key_press_r;
   assign key_release = key_release_r;
   assign key_long    = key_long_r;
   assign key_repeat  = key_repeat_r;

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side companion to the LED output driver: debounces one mechanical push-button and turns it into clean level and event pulses for the control logic.
- Shares the LED driver's timebase scheme: a free-running 1 us prescaler feeding a 1 ms tick counter, sized for a 24 MHz clock.
- Debounce, long-press and auto-repeat timing are all counted in whole ms ticks.

Parameters:
- CLK_PER_US, 24, clk cycles per 1 us tick (>=2).
- US_PER_MS, 1000, us ticks per 1 ms tick (>=2).
- DEBOUNCE_MS, 20, ms the input must hold a new level before it is accepted (>=1).
- LONG_MS, 1000, ms held, measured from press acceptance, before key_long fires (>DEBOUNCE_MS).
- REPEAT_MS, 200, auto-repeat period after key_long; used only with KEY_REPEAT_EN (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- key_in  input  1  raw button, active-low (0 = pressed), asynchronous to clk.
- key_level  output  1  debounced state, 1 = pressed.
- key_press  output  1  one-cycle pulse on accepted press.
- key_release  output  1  one-cycle pulse on accepted release.
- key_long  output  1  one-cycle pulse when hold time reaches LONG_MS.
- key_repeat  output  1  one-cycle repeat pulse; tied 0 without KEY_REPEAT_EN.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters 0; both sync flops 1 (released).
- Synchroniser:
  - Two flops on key_in.
  - key_s = inverted second flop, so 1 = pressed.
  - 2-cycle input latency.
- us prescaler:
  - us_cnt counts 0..CLK_PER_US-1, then wraps to 0.
  - us_tick is asserted when us_cnt == CLK_PER_US-1.
- ms counter:
  - ms_cnt advances only on us_tick and wraps after US_PER_MS-1.
  - ms_tick = us_tick && ms_cnt == US_PER_MS-1, so one ms_tick every CLK_PER_US*US_PER_MS clocks.
  - Both prescalers are free-running from reset and are never restarted by FSM activity.
- FSM states: IDLE, PRESS_CHK, PRESSED, REL_CHK.
  - IDLE: when key_s=1, go to PRESS_CHK and clear deb_cnt.
  - PRESS_CHK:
    - key_s=0 → IDLE, clear deb_cnt (bounce rejected).
    - Otherwise each ms_tick increments deb_cnt.
    - On the ms_tick with deb_cnt==DEBOUNCE_MS-1 → PRESSED.
    - The press is therefore accepted between (DEBOUNCE_MS-1) and DEBOUNCE_MS ms after key_s rises.
  - PRESSED: when key_s=0, go to REL_CHK and clear deb_cnt.
  - REL_CHK: mirror of PRESS_CHK.
    - key_s=1 → back to PRESSED; hold_cnt is kept.
    - On acceptance → IDLE.
- Output timing:
  - key_press and key_level rise in the same cycle, registered, on the cycle after the accepting ms_tick.
  - key_release is asserted together with key_level falling.
  - Exactly one key_press per accepted press and one key_release per accepted release; never both in one cycle.
- Hold timing:
  - hold_cnt clears on entry to PRESSED from PRESS_CHK.
  - It increments on ms_tick while in PRESSED or REL_CHK.
  - It saturates at LONG_MS.
  - key_long pulses once, in the cycle after hold_cnt reaches LONG_MS.
  - A release accepted before then means no key_long.
- Counter widths: $clog2 of the respective maximum + 1; no wrap beyond the maximum; hold_cnt saturates.
- Reset mid-operation: returns to IDLE with outputs 0; no key_release is emitted for the aborted press.
- A key held through reset is re-detected as a new press after the debounce time.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - After key_long, rep_cnt counts ms_ticks while pressed.
  - key_repeat pulses for one cycle every REPEAT_MS ms.
  - The first pulse comes REPEAT_MS ms after key_long.
  - rep_cnt clears on accepted release and on reset.
  - key_repeat never coincides with key_long.
- Undefined: no rep_cnt logic; key_repeat is driven constant 0.

Test Plan:
All scenarios use CLK_PER_US=2, US_PER_MS=4 (ms_tick every 8 clk), DEBOUNCE_MS=3, LONG_MS=10, REPEAT_MS=4.
1. Clean press:
   - Stimulus: key_in to 0 and held 100 clk.
   - Required: exactly one key_press and key_level=1 within 19–27 clk after the edge (2 sync + 16–24 debounce + 1 register); no key_release.
2. Bounce rejection:
   - Stimulus: key_in toggles 0/1 every 5 clk for 60 clk, then stays 1.
   - Required: key_press never asserted; key_level stays 0.
3. Release plus release-side glitch:
   - Stimulus: after an accepted press, key_in=1 for 6 clk, 0 for 10 clk, then 1 held.
   - Required: exactly one key_release, 19–27 clk after the final rising edge; no extra key_press.
4. Long press:
   - Stimulus: key_in held 0 for 150 clk.
   - Required: key_long pulses exactly once, 80 clk (10 ms ticks) after key_press, ±1 ms tick; held 60 clk only → no key_long.
5. Reset mid-press:
   - Stimulus: assert reset for 1 clk at 40 clk into a held press.
   - Required: all outputs 0 next cycle, no key_release; a fresh key_press arrives 16–24 clk + 3 clk after reset deasserts.
6. KEY_REPEAT_EN defined:
   - Stimulus: key_in held 0 for 200 clk.
   - Required: key_repeat pulses at 32, 64 and 96 clk after key_long; after release and reset, key_repeat stays 0.
   - Without the macro: key_repeat stays 0 throughout.
